booth_div: RTL and testbench
============================

Name: booth_div

Overview:
- Sequential signed integer divider; the inverse-operation companion of the team's Booth multiplier.
- Same datapath style and start/done completion handshake; sits beside the multiplier in the arithmetic library.
- Computes quotient and remainder of two's-complement operands by restoring division on magnitudes, followed by sign correction.
- Fixed latency regardless of operand values.

Parameters:
- WIDTH, 4, operand/result width in bits (>= 2).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- div_start  input  1  request; sampled only in IDLE.
- div_a  input  WIDTH  signed dividend, captured when start is accepted.
- div_b  input  WIDTH  signed divisor, captured when start is accepted.
- div_q  output  WIDTH  signed quotient, registered.
- div_r  output  WIDTH  signed remainder, registered.
- div_busy  output  1  high from acceptance until the cycle div_done is asserted.
- div_done  output  1  one-cycle pulse; results valid from this cycle.
- div_by_zero  output  1  divisor was 0; updated with div_done.
- div_ovf  output  1  quotient unrepresentable (most-negative / -1); updated with div_done.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State returns to IDLE.
  - div_q, div_r, div_busy, div_done, div_by_zero, div_ovf all go to 0.
  - Reset overrides any operation in flight; no div_done is produced for an aborted operation.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE:
  - If div_start=1, capture div_a and div_b.
  - Store the sign bits and the magnitudes |a| and |b| in WIDTH-bit unsigned form (|-2^(WIDTH-1)| = 2^(WIDTH-1) fits).
  - Clear the partial remainder (WIDTH+1 bits), load the iteration counter with WIDTH, set div_busy, go to CALC.
- CALC, one iteration per cycle for WIDTH cycles:
  - Shift {rem, quo} left by 1, bringing in the next dividend-magnitude bit (MSB first).
  - Trial-subtract |b|. If the result is non-negative, keep it and set quo LSB to 1; otherwise restore and set LSB to 0.
  - Decrement the counter; go to FIX after the WIDTH-th iteration.
- FIX:
  - Quotient negated if sign_a XOR sign_b.
  - Remainder negated if sign_a. This gives truncation toward zero, with the remainder taking the sign of the dividend.
  - Results are registered into div_q and div_r.
  - div_ovf = (a == -2^(WIDTH-1)) AND (b == -1).
  - div_by_zero = (b == 0).
  - Go to DONE.
- DONE:
  - div_done=1 for exactly this cycle; div_busy falls in this cycle; return to IDLE.
- Latency: if div_start is sampled at edge N, div_done is high in the cycle following edge N+WIDTH+2. This gives 7 cycles total for WIDTH=4.
- div_start while busy (CALC/FIX/DONE): ignored; the in-flight operation is unaffected.
- div_start held high continuously: a new operation is accepted in the IDLE cycle after DONE, giving back-to-back operations every WIDTH+3 cycles.
- Outputs hold their last result until the next FIX or a reset.
- Divide by zero:
  - The algorithm runs unchanged and takes the full latency.
  - The result is forced: div_q = all ones (-1), div_r = div_a, div_by_zero=1, div_ovf=0.
- Overflow: div_q = -2^(WIDTH-1) (wrapped), div_r = 0, div_ovf=1.
- No other inputs are sampled outside IDLE; operand changes during CALC have no effect.

Test Plan:
- WIDTH=4, a=7, b=2 -> after 7 cycles: q=4'b0011 (3), r=4'b0001 (1), both flags 0, div_done high for one cycle.
- a=-7, b=2 -> q=4'b1101 (-3), r=4'b1111 (-1). Then a=4, b=-5 -> q=0, r=4.
- a=-8, b=-1 -> q=4'b1000, r=0, div_ovf=1. Then a=5, b=0 -> q=4'b1111, r=4'b0101, div_by_zero=1, div_ovf=0.
- Sweep: a=4, b stepped from -5 upward by +1 on each div_done for 20 operations (wrapping) -> every result matches truncating C-style division; the b=0 step flags divide-by-zero.
- div_start pulsed in cycle 3 of an operation with different operands -> ignored, original result returned. div_start held high -> div_done spaced exactly 7 cycles apart.
- rst asserted in cycle 2 of CALC -> all outputs 0 next cycle, no div_done. A new start after release yields the correct result at the full latency.

Source files
------------

// File: rtl/booth_div.sv
// Sequential signed divider: restoring division on operand magnitudes, then sign fix-up.
// Fixed latency of WIDTH+3 cycles from accepted start to the div_done pulse.
module booth_div #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_start,
  input  logic [WIDTH-1:0] div_a,
  input  logic [WIDTH-1:0] div_b,
  output logic [WIDTH-1:0] div_q,
  output logic [WIDTH-1:0] div_r,
  output logic             div_busy,
  output logic             div_done,
  output logic             div_by_zero,
  output logic             div_ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] quo;
  logic [WIDTH:0]   rem;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH+1:0] rem_sh, trial;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic             b_zero, ovf_case;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (div_start) state_next = CALC;
      CALC:    if (cnt == CW'(1)) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The trial subtraction is two bits wider than the divisor so its MSB is a clean borrow flag.
  always_comb begin
    abs_a    = div_a[WIDTH-1] ? -div_a : div_a;
    abs_b    = div_b[WIDTH-1] ? -div_b : div_b;
    rem_sh   = {rem, quo[WIDTH-1]};
    trial    = rem_sh - {2'b00, mag_b};
    b_zero   = (b_reg == '0);
    ovf_case = (a_reg == {1'b1, {(WIDTH-1){1'b0}}}) && (b_reg == '1);
    q_fix    = (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]) ? -quo : quo;
    r_fix    = a_reg[WIDTH-1] ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    if (b_zero) begin
      q_fix = '1;
      r_fix = a_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg       <= '0;
      b_reg       <= '0;
      mag_b       <= '0;
      quo         <= '0;
      rem         <= '0;
      cnt         <= '0;
      div_q       <= '0;
      div_r       <= '0;
      div_busy    <= 1'b0;
      div_done    <= 1'b0;
      div_by_zero <= 1'b0;
      div_ovf     <= 1'b0;
    end else begin
      div_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (div_start) begin
            a_reg    <= div_a;
            b_reg    <= div_b;
            quo      <= abs_a;
            mag_b    <= abs_b;
            rem      <= '0;
            cnt      <= CW'(WIDTH);
            div_busy <= 1'b1;
          end
        end
        CALC: begin
          rem <= trial[WIDTH+1] ? rem_sh[WIDTH:0] : trial[WIDTH:0];
          quo <= {quo[WIDTH-2:0], ~trial[WIDTH+1]};
          cnt <= cnt - CW'(1);
        end
        FIX: begin
          div_q       <= q_fix;
          div_r       <= r_fix;
          div_by_zero <= b_zero;
          div_ovf     <= ovf_case;
        end
        DONE: begin
          div_done <= 1'b1;
          div_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_div.sv
// Bench for booth_div (WIDTH=4): table vectors and a sweep feed a scoreboard queue,
// plus hand-written sequences for busy-start, held start and mid-operation reset.
module tb_booth_div;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         div_start;
  logic [W-1:0] div_a, div_b;
  logic [W-1:0] div_q, div_r;
  logic         div_busy, div_done, div_by_zero, div_ovf;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ovf;
  } vec_t;

  vec_t exp_q[$];
  vec_t mon_e;
  vec_t table_v[$];

  int tests_run;
  int tests_failed;

  booth_div #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .div_start  (div_start),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_q      (div_q),
    .div_r      (div_r),
    .div_busy   (div_busy),
    .div_done   (div_done),
    .div_by_zero(div_by_zero),
    .div_ovf    (div_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input int a, input int b, input int q, input int r,
                              input logic dz, input logic ovf);
    vec_t v;
    v.a   = 4'(a);
    v.b   = 4'(b);
    v.q   = 4'(q);
    v.r   = 4'(r);
    v.dz  = dz;
    v.ovf = ovf;
    return v;
  endfunction

  // Reference uses the simulator's own truncating integer division.
  function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    int ai;
    int bi;
    ai = int'($signed(a));
    bi = int'($signed(b));
    if (bi == 0) return mk(ai, bi, -1, ai, 1'b1, 1'b0);
    if (ai == -8 && bi == -1) return mk(ai, bi, -8, 0, 1'b0, 1'b1);
    return mk(ai, bi, ai / bi, ai % bi, 1'b0, 1'b0);
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && div_done) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("q", int'(div_q), int'(mon_e.q));
        checkOutput("r", int'(div_r), int'(mon_e.r));
        checkOutput("by_zero", int'(div_by_zero), int'(mon_e.dz));
        checkOutput("ovf", int'(div_ovf), int'(mon_e.ovf));
      end
    end
  end

  task automatic applyStimulus(input vec_t v, input bit intrude);
    int k;
    bit seen;
    @(negedge clk);
    div_a     = v.a;
    div_b     = v.b;
    div_start = 1'b1;
    exp_q.push_back(v);
    seen = 1'b0;
    k    = 0;
    while (!seen && k < 30) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        div_start = 1'b0;
        checkOutput("busy_after_start", int'(div_busy), 1);
      end
      if (intrude && k == 2) begin
        div_a     = ~v.a;
        div_b     = 4'd3;
        div_start = 1'b1;
      end
      if (intrude && k == 3) div_start = 1'b0;
      if (div_done) seen = 1'b1;
    end
    checkOutput("latency", k, 7);
    checkOutput("busy_at_done", int'(div_busy), 0);
    @(negedge clk);
    checkOutput("done_one_cycle", int'(div_done), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t v;
    logic [W-1:0] bs;
    int n;
    int k;
    int last_k;
    int seen_done;

    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    div_start    = 1'b0;
    div_a        = '0;
    div_b        = '0;

    table_v.push_back(mk( 7,  2,  3,  1, 1'b0, 1'b0));
    table_v.push_back(mk(-7,  2, -3, -1, 1'b0, 1'b0));
    table_v.push_back(mk( 4, -5,  0,  4, 1'b0, 1'b0));
    table_v.push_back(mk(-8, -1, -8,  0, 1'b0, 1'b1));
    table_v.push_back(mk( 5,  0, -1,  5, 1'b1, 1'b0));
    table_v.push_back(mk(-8,  3, -2, -2, 1'b0, 1'b0));
    table_v.push_back(mk( 7, -8,  0,  7, 1'b0, 1'b0));
    table_v.push_back(mk(-8, -8,  1,  0, 1'b0, 1'b0));
    table_v.push_back(mk(-8,  7, -1, -1, 1'b0, 1'b0));

    repeat (3) @(negedge clk);
    checkOutput("reset_q", int'(div_q), 0);
    checkOutput("reset_r", int'(div_r), 0);
    checkOutput("reset_busy", int'(div_busy), 0);
    checkOutput("reset_done", int'(div_done), 0);
    checkOutput("reset_by_zero", int'(div_by_zero), 0);
    checkOutput("reset_ovf", int'(div_ovf), 0);
    rst = 1'b0;

    foreach (table_v[i]) applyStimulus(table_v[i], 1'b0);

    bs = 4'(-5);
    for (int i = 0; i < 20; i++) begin
      v = model(4'd4, bs);
      applyStimulus(v, 1'b0);
      bs = bs + 4'd1;
    end

    // Start pulsed mid-operation with other operands must not disturb the result.
    applyStimulus(mk(7, 2, 3, 1, 1'b0, 1'b0), 1'b1);
    repeat (10) @(negedge clk);

    // Held start: three back-to-back operations, done pulses 7 cycles apart.
    v = mk(-7, 2, -3, -1, 1'b0, 1'b0);
    repeat (3) exp_q.push_back(v);
    @(negedge clk);
    div_a     = v.a;
    div_b     = v.b;
    div_start = 1'b1;
    n      = 0;
    k      = 0;
    last_k = 0;
    while (n < 3 && k < 60) begin
      @(negedge clk);
      k++;
      if (div_done) begin
        n++;
        if (n == 1) checkOutput("held_first_latency", k, 7);
        else checkOutput("held_spacing", k - last_k, 7);
        last_k = k;
        if (n == 3) div_start = 1'b0;
      end
    end
    div_start = 1'b0;
    checkOutput("held_count", n, 3);
    repeat (3) @(negedge clk);

    // Reset during the second CALC cycle aborts the operation silently.
    div_a     = 4'd5;
    div_b     = 4'd2;
    div_start = 1'b1;
    @(negedge clk);
    div_start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_q", int'(div_q), 0);
    checkOutput("abort_r", int'(div_r), 0);
    checkOutput("abort_busy", int'(div_busy), 0);
    checkOutput("abort_done", int'(div_done), 0);
    checkOutput("abort_by_zero", int'(div_by_zero), 0);
    checkOutput("abort_ovf", int'(div_ovf), 0);
    rst = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (div_done) seen_done++;
    end
    checkOutput("no_done_after_abort", seen_done, 0);
    applyStimulus(mk(7, 2, 3, 1, 1'b0, 1'b0), 1'b0);

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
